// File: rtl/fifo_ctrl_fsm_if.sv
// Handshake/config bundle between the FIFO bank, config block and the FIFO control FSM.
// Ports: slave = FSM side (takes config/status, drives state/thresholds/error info); master = driver side.
interface fifo_ctrl_fsm_if #(
    parameter int NUM_FIFOS = 5,
    parameter int THR_W     = 4,
    parameter int CNT_W     = 4
);
    logic                 init;
    logic                 err_clr;
    logic [THR_W-1:0]     thr_mf;
    logic [THR_W-1:0]     thr_vc;
    logic [THR_W-1:0]     thr_d;
    logic [NUM_FIFOS-1:0] fifo_empty;
    logic [NUM_FIFOS-1:0] fifo_error;

    logic                 init_out;
    logic                 idle_out;
    logic                 active_out;
    logic                 error_out;
    logic [THR_W-1:0]     thr_mf_out;
    logic [THR_W-1:0]     thr_vc_out;
    logic [THR_W-1:0]     thr_d_out;
    logic [NUM_FIFOS-1:0] err_src;
    logic [CNT_W-1:0]     err_cnt;
    logic [2:0]           state;

    modport master (
        output init, err_clr, thr_mf, thr_vc, thr_d,
        output fifo_empty, fifo_error,
        input  init_out, idle_out, active_out, error_out,
        input  thr_mf_out, thr_vc_out, thr_d_out,
        input  err_src, err_cnt, state
    );

    modport slave (
        input  init, err_clr, thr_mf, thr_vc, thr_d,
        input  fifo_empty, fifo_error,
        output init_out, idle_out, active_out, error_out,
        output thr_mf_out, thr_vc_out, thr_d_out,
        output err_src, err_cnt, state
    );
endinterface

// File: rtl/fifo_ctrl_fsm.sv
// Control FSM for a bank of FIFOs: RESET/INIT/IDLE/ACTIVE/ERROR sequencing, threshold capture,
// error-source latching, saturating error-event count. Ports: clk, reset (sync, high), bus (slave).
module fifo_ctrl_fsm #(
    parameter int NUM_FIFOS = 5,
    parameter int THR_W     = 4,
    parameter int IDLE_DLY  = 4,
    parameter int CNT_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    fifo_ctrl_fsm_if.slave  bus
);

    localparam int EC_W = $clog2(IDLE_DLY + 1);
    localparam logic [EC_W-1:0]  DLY     = EC_W'(IDLE_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [THR_W-1:0]     mf_q, mf_d;
    logic [THR_W-1:0]     vc_q, vc_d;
    logic [THR_W-1:0]     dd_q, dd_d;
    logic [NUM_FIFOS-1:0] src_q, src_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [EC_W-1:0]      ecnt_q, ecnt_d;

    logic all_empty;
    logic any_err;

    assign all_empty = &bus.fifo_empty;
    assign any_err   = |bus.fifo_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            mf_q    <= '0;
            vc_q    <= '0;
            dd_q    <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mf_q    <= mf_d;
            vc_q    <= vc_d;
            dd_q    <= dd_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mf_d    = mf_q;
        vc_d    = vc_q;
        dd_d    = dd_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        // Empty-run counter only lives inside ACTIVE, so ACTIVE is always entered at zero.
        ecnt_d  = '0;

        case (state_q)
            S_RESET: state_d = S_INIT;

            S_INIT: begin
                mf_d    = bus.thr_mf;
                vc_d    = bus.thr_vc;
                dd_d    = bus.thr_d;
                src_d   = '0;
                state_d = S_IDLE;
            end

            S_IDLE: begin
                if (bus.init)        state_d = S_INIT;
                else if (any_err)    state_d = S_ERROR;
                else if (!all_empty) state_d = S_ACTIVE;
            end

            S_ACTIVE: begin
                if (bus.init)        state_d = S_INIT;
                else if (any_err)    state_d = S_ERROR;
                else if (!all_empty) ecnt_d  = '0;
                else if (ecnt_q + 1'b1 == DLY)
                    state_d = S_IDLE;
                else
                    ecnt_d = ecnt_q + 1'b1;
            end

            S_ERROR: begin
                // init is deliberately ignored here; only err_clr leaves ERROR.
                src_d = src_q | bus.fifo_error;
                if (bus.err_clr && !any_err)
                    state_d = S_INIT;
            end

            default: state_d = S_RESET;
        endcase

        // Entry into ERROR: restart the source capture with the triggering flags.
        if (state_d == S_ERROR && state_q != S_ERROR) begin
            src_d = bus.fifo_error;
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end

        if (state_d == S_INIT)
            src_d = '0;
    end

    assign bus.init_out   = (state_q == S_INIT);
    assign bus.idle_out   = (state_q == S_IDLE);
    assign bus.active_out = (state_q == S_ACTIVE);
    assign bus.error_out  = (state_q == S_ERROR);
    assign bus.thr_mf_out = mf_q;
    assign bus.thr_vc_out = vc_q;
    assign bus.thr_d_out  = dd_q;
    assign bus.err_src    = src_q;
    assign bus.err_cnt    = cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Directed scoreboard bench for fifo_ctrl_fsm.
// Expectations queued per cycle, popped and checked after each rising edge.
module tb_fifo_ctrl_fsm;

    localparam logic [2:0] RST = 3'd0;
    localparam logic [2:0] INI = 3'd1;
    localparam logic [2:0] IDL = 3'd2;
    localparam logic [2:0] ACT = 3'd3;
    localparam logic [2:0] ERR = 3'd4;

    typedef struct {
        logic [2:0] st;
        logic [4:0] src;
        logic [3:0] cnt;
        logic [3:0] mf;
        logic [3:0] vc;
        logic [3:0] d;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [4:0] exp_src;
    logic [3:0] exp_cnt;
    logic [3:0] exp_mf;
    logic [3:0] exp_vc;
    logic [3:0] exp_d;

    fifo_ctrl_fsm_if #(.NUM_FIFOS(5), .THR_W(4), .CNT_W(4)) bus ();

    fifo_ctrl_fsm #(
        .NUM_FIFOS(5),
        .THR_W(4),
        .IDLE_DLY(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [2:0] st);
        exp_t e;
        exp_t g;
        e.st  = st;
        e.src = exp_src;
        e.cnt = exp_cnt;
        e.mf  = exp_mf;
        e.vc  = exp_vc;
        e.d   = exp_d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            g = sb.pop_front();
            chk("state", 32'(bus.state), 32'(g.st));
            chk("flags",
                32'({bus.init_out, bus.idle_out, bus.active_out, bus.error_out}),
                32'({g.st == INI, g.st == IDL, g.st == ACT, g.st == ERR}));
            chk("err_src", 32'(bus.err_src), 32'(g.src));
            chk("err_cnt", 32'(bus.err_cnt), 32'(g.cnt));
            chk("thr_mf", 32'(bus.thr_mf_out), 32'(g.mf));
            chk("thr_vc", 32'(bus.thr_vc_out), 32'(g.vc));
            chk("thr_d", 32'(bus.thr_d_out), 32'(g.d));
        end
    endtask

    task automatic set_thr(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c);
        bus.thr_mf = a;
        bus.thr_vc = b;
        bus.thr_d  = c;
    endtask

    task automatic zero_exp();
        exp_src = '0;
        exp_cnt = '0;
        exp_mf  = '0;
        exp_vc  = '0;
        exp_d   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        zero_exp();
        reset          = 1'b1;
        bus.init       = 1'b0;
        bus.err_clr    = 1'b0;
        bus.fifo_empty = 5'b11111;
        bus.fifo_error = 5'b00000;
        set_thr(4'h3, 4'hA, 4'h5);

        // Reset for 3 cycles, then RESET -> INIT -> IDLE with captured thresholds
        tick(RST);
        tick(RST);
        tick(RST);
        reset = 1'b0;
        tick(INI);
        exp_mf = 4'h3; exp_vc = 4'hA; exp_d = 4'h5;
        tick(IDL);
        set_thr(4'hF, 4'hF, 4'hF);
        tick(IDL);

        // IDLE -> ACTIVE, empty run broken on 3rd cycle, then 4 empties -> IDLE
        bus.fifo_empty = 5'b11110;
        tick(ACT);
        bus.fifo_empty = 5'b11111;
        tick(ACT);
        tick(ACT);
        bus.fifo_empty = 5'b11101;
        tick(ACT);
        bus.fifo_empty = 5'b11111;
        tick(ACT);
        tick(ACT);
        tick(ACT);
        tick(IDL);

        // ACTIVE errors accumulate into err_src
        bus.fifo_empty = 5'b11110;
        tick(ACT);
        bus.fifo_error = 5'b00100;
        exp_src = 5'b00100; exp_cnt = 4'd1;
        tick(ERR);
        bus.fifo_error = 5'b01000;
        exp_src = 5'b01100;
        tick(ERR);

        // err_clr blocked while an error is still asserted, then recovery
        bus.err_clr = 1'b1;
        tick(ERR);
        bus.fifo_error = 5'b00000;
        bus.fifo_empty = 5'b11111;
        exp_src = 5'b00000;
        tick(INI);
        bus.err_clr = 1'b0;
        set_thr(4'h6, 4'h7, 4'h8);
        exp_mf = 4'h6; exp_vc = 4'h7; exp_d = 4'h8;
        tick(IDL);

        // init ignored in ERROR
        bus.fifo_error = 5'b00001;
        exp_src = 5'b00001; exp_cnt = 4'd2;
        tick(ERR);
        bus.fifo_error = 5'b00000;
        bus.init = 1'b1;
        tick(ERR);
        bus.init = 1'b0;
        bus.err_clr = 1'b1;
        exp_src = 5'b00000;
        tick(INI);
        bus.err_clr = 1'b0;
        tick(IDL);

        // 15 more episodes: counter saturates at 15
        for (int i = 0; i < 15; i++) begin
            bus.fifo_error = 5'b10000;
            exp_src = 5'b10000;
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            tick(ERR);
            bus.fifo_error = 5'b00000;
            bus.err_clr = 1'b1;
            exp_src = 5'b00000;
            tick(INI);
            bus.err_clr = 1'b0;
            tick(IDL);
        end
        chk("err_cnt_sat", 32'(bus.err_cnt), 32'd15);

        // init in ACTIVE recaptures thresholds
        bus.fifo_empty = 5'b11110;
        tick(ACT);
        set_thr(4'h9, 4'hB, 4'hC);
        bus.init = 1'b1;
        tick(INI);
        bus.init = 1'b0;
        bus.fifo_empty = 5'b11111;
        exp_mf = 4'h9; exp_vc = 4'hB; exp_d = 4'hC;
        tick(IDL);

        // init has priority over error in IDLE
        bus.init = 1'b1;
        bus.fifo_error = 5'b00010;
        tick(INI);
        bus.init = 1'b0;
        bus.fifo_error = 5'b00000;
        tick(IDL);

        // reset in ACTIVE
        bus.fifo_empty = 5'b11110;
        tick(ACT);
        reset = 1'b1;
        zero_exp();
        tick(RST);
        reset = 1'b0;
        bus.fifo_empty = 5'b11111;
        tick(INI);
        exp_mf = 4'h9; exp_vc = 4'hB; exp_d = 4'hC;
        tick(IDL);

        // reset in ERROR
        bus.fifo_error = 5'b00010;
        exp_src = 5'b00010; exp_cnt = 4'd1;
        tick(ERR);
        bus.fifo_error = 5'b00000;
        reset = 1'b1;
        zero_exp();
        tick(RST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
